// File: rtl/adc_align_pkg.sv
// Shared types and defaults for the ADC frame-alignment controller.
// Optional statistics counters are enabled with ADC_ALIGN_STATS_EN.
package adc_align_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } align_state_t;

  localparam int         DEF_FRAME_W   = 8;
  localparam logic [7:0] DEF_FRAME_PAT = 8'hF0;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_align_timer.sv
// Loadable down-counter with a zero flag.
// Shared by the ISERDES-reset and settle waits.
module adc_align_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/adc_align_ctrl.sv
// Frame-alignment controller: ISERDES reset, bitslip search, lock watch.
// Define ADC_ALIGN_STATS_EN to add lock_loss_cnt and total_slips.
module adc_align_ctrl
  import adc_align_pkg::*;
#(
  parameter int                 FRAME_W       = DEF_FRAME_W,
  parameter logic [FRAME_W-1:0] FRAME_PAT     = DEF_FRAME_PAT,
  parameter int                 RST_CYCLES    = 16,
  parameter int                 SETTLE_CYCLES = 4,
  parameter int                 MAX_RETRY     = 3,
  parameter int                 LOSS_THRESH   = 4
) (
  input  logic                       clk,
  input  logic                       cpu_resetn,
  input  logic                       start,
  input  logic [FRAME_W-1:0]         frame_word,
  output logic                       iserdes_rst,
  output logic                       bitslip,
  output logic                       locked,
  output logic                       fail,
`ifdef ADC_ALIGN_STATS_EN
  output logic [7:0]                 lock_loss_cnt,
  output logic [15:0]                total_slips,
`endif
  output logic [$clog2(FRAME_W)-1:0] slip_cnt
);

  localparam int SW = $clog2(FRAME_W);
  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ?
                        RST_CYCLES : SETTLE_CYCLES;
  localparam int TW = cnt_w(TMAX);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int MW = cnt_w(LOSS_THRESH);

  localparam logic [TW-1:0] RST_LOAD    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(FRAME_W - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);
  localparam logic [MW-1:0] MISS_LAST   = MW'(LOSS_THRESH - 1);

  align_state_t  state;
  logic [RW-1:0] retry_cnt;
  logic [MW-1:0] miss_cnt;

  logic          match;
  logic          sweep_done;
  logic          retry_last;
  logic          slip_go;
  logic          sweep_retry;
  logic          sweep_fail;
  logic          loss;
  logic          to_rst;
  logic          to_settle;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  assign match      = (frame_word == FRAME_PAT);
  assign sweep_done = (slip_cnt == SLIP_MAX);
  assign retry_last = (retry_cnt == RETRY_LAST);

  always_comb begin
    slip_go     = 1'b0;
    sweep_retry = 1'b0;
    sweep_fail  = 1'b0;
    loss        = 1'b0;
    to_settle   = 1'b0;
    if (!start) begin
      unique case (1'b1)
        (state == S_CHECK): begin
          slip_go     = !match && !sweep_done;
          sweep_retry = !match && sweep_done && !retry_last;
          sweep_fail  = !match && sweep_done && retry_last;
        end
        (state == S_LOCKED): loss      = !match && (miss_cnt == MISS_LAST);
        (state == S_RST):    to_settle = tmr_done;
        (state == S_SLIP):   to_settle = 1'b1;
        default: ;
      endcase
    end
  end

  // Every path into RST reloads the reset hold, so start restarts it.
  assign to_rst   = start || sweep_retry || loss;
  assign tmr_load = to_rst || to_settle;
  assign tmr_val  = to_rst ? RST_LOAD : SETTLE_LOAD;

  adc_align_timer #(
    .W       (TW),
    .RST_VAL (RST_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (cpu_resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state       <= S_RST;
      iserdes_rst <= 1'b1;
      bitslip     <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      slip_cnt    <= '0;
      retry_cnt   <= '0;
      miss_cnt    <= '0;
    end else begin
      bitslip <= 1'b0;
      if (start) begin
        state       <= S_RST;
        iserdes_rst <= 1'b1;
        locked      <= 1'b0;
        fail        <= 1'b0;
        slip_cnt    <= '0;
        retry_cnt   <= '0;
        miss_cnt    <= '0;
      end else begin
        case (state)
          S_RST: begin
            if (tmr_done) begin
              state       <= S_SETTLE;
              iserdes_rst <= 1'b0;
            end
          end
          S_SETTLE: begin
            if (tmr_done) state <= S_CHECK;
          end
          S_CHECK: begin
            if (match) begin
              state    <= S_LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end else if (slip_go) begin
              state    <= S_SLIP;
              bitslip  <= 1'b1;
              slip_cnt <= slip_cnt + 1'b1;
            end else if (sweep_fail) begin
              state     <= S_FAIL;
              fail      <= 1'b1;
              retry_cnt <= retry_cnt + 1'b1;
            end else begin
              state       <= S_RST;
              iserdes_rst <= 1'b1;
              slip_cnt    <= '0;
              retry_cnt   <= retry_cnt + 1'b1;
            end
          end
          S_SLIP: state <= S_SETTLE;
          S_LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
            end else if (loss) begin
              state       <= S_RST;
              locked      <= 1'b0;
              iserdes_rst <= 1'b1;
              slip_cnt    <= '0;
              retry_cnt   <= '0;
              miss_cnt    <= '0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          S_FAIL: ;
          default: begin
            state       <= S_RST;
            iserdes_rst <= 1'b1;
            locked      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ADC_ALIGN_STATS_EN
  // Survives start so software can read history across retrains.
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      lock_loss_cnt <= '0;
      total_slips   <= '0;
    end else begin
      if (loss && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      if (slip_go && total_slips != 16'hFFFF)
        total_slips <= total_slips + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed/random bench for adc_align_ctrl with a rotating-frame model.
// Build with ADC_ALIGN_STATS_EN defined to also check the stats ports.
module tb_adc_align_ctrl;

  localparam logic [7:0] PAT = 8'hF0;
  localparam int RSTC = 16;
  localparam int SETC = 4;
  localparam int SWEEP = RSTC + SETC + 1 + 7 * (1 + SETC + 1);

  logic       clk = 1'b0;
  logic       cpu_resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_word;
  logic       iserdes_rst;
  logic       bitslip;
  logic       locked;
  logic       fail;
  logic [2:0] slip_cnt;
`ifdef ADC_ALIGN_STATS_EN
  logic [7:0]  lock_loss_cnt;
  logic [15:0] total_slips;
`endif

  adc_align_ctrl dut (
    .clk         (clk),
    .cpu_resetn  (cpu_resetn),
    .start       (start),
    .frame_word  (frame_word),
    .iserdes_rst (iserdes_rst),
    .bitslip     (bitslip),
    .locked      (locked),
    .fail        (fail),
`ifdef ADC_ALIGN_STATS_EN
    .lock_loss_cnt (lock_loss_cnt),
    .total_slips   (total_slips),
`endif
    .slip_cnt    (slip_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Lane model: rotation reloads on ISERDES reset, each slip removes one step.
  int         offset = 0;
  int         rot = 0;
  logic       stuck = 1'b0;
  logic       inj = 1'b0;
  logic [7:0] inj_val = 8'h0F;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int r);
    logic [15:0] d;
    d = {v, v} << r;
    return d[15:8];
  endfunction

  always @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn)   rot <= offset;
    else if (iserdes_rst) rot <= offset;
    else if (bitslip)  rot <= (rot + 7) % 8;
  end

  always_comb begin
    frame_word = rotl(PAT, rot);
    if (inj)   frame_word = inj_val;
    if (stuck) frame_word = 8'h00;
  end

  // Output monitor: reset-run lengths, slip spacing, exclusivity.
  logic mon_clr = 1'b0;
  int rst_run = 0, n_rst_runs = 0, rst_bad = 0;
  int n_slips = 0, since_slip = 100, gap_bad = 0;
  int excl_bad = 0;

  always @(negedge clk) begin
    if (mon_clr) begin
      rst_run = 0; n_rst_runs = 0; rst_bad = 0;
      n_slips = 0; since_slip = 100; gap_bad = 0;
    end else if (cpu_resetn) begin
      if (iserdes_rst) rst_run++;
      else if (rst_run != 0) begin
        n_rst_runs++;
        if (rst_run != RSTC) rst_bad++;
        rst_run = 0;
      end
      if (bitslip) begin
        n_slips++;
        if (since_slip < SETC) gap_bad++;
        since_slip = 0;
      end else if (since_slip < 100) since_slip++;
      if (locked && (iserdes_rst || bitslip || fail)) excl_bad++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input int off);
    cpu_resetn = 1'b0;
    start = 1'b0; inj = 1'b0; stuck = 1'b0;
    offset = off;
    @(negedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    @(posedge clk); #1 cpu_resetn = 1'b1;
  endtask

  task automatic wait_lock(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!locked && n < budget);
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Four consecutive mismatches must drop lock right after the fourth.
  task automatic force_loss;
    @(negedge clk);
    inj = 1'b1;
    inj_val = 8'($urandom_range(0, 255));
    if (inj_val == PAT) inj_val = 8'h3C;
    repeat (3) begin
      @(negedge clk);
      chk("loss_hold", locked, 1);
    end
    @(negedge clk);
    inj = 1'b0;
    chk("loss_unlock", locked, 0);
    chk("loss_rst", iserdes_rst, 1);
  endtask

  initial begin
    int n, k, found;

    // Reset values
    apply_reset(0);
    cpu_resetn = 1'b0;
    #1;
    chk("rst_iserdes", iserdes_rst, 1);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", fail, 0);
    chk("rst_slipcnt", slip_cnt, 0);

    // Offset 0: no slips, lock after reset hold and one settle
    apply_reset(0);
    wait_lock(200, n);
    chk("off0_lat", n, RSTC + SETC + 2);
    chk("off0_slips", n_slips, 0);
    chk("off0_slipcnt", slip_cnt, 0);
    chk("off0_runs", n_rst_runs, 1);
    chk("off0_runlen", rst_bad, 0);

    // Offset 3 plus random offsets: one slip per step of misalignment
    for (int i = 0; i < 4; i++) begin
      k = (i == 0) ? 3 : int'($urandom_range(1, 7));
      apply_reset(k);
      wait_lock(300, n);
      chk("off_lat", n, RSTC + SETC + 2 + k * (SETC + 2));
      chk("off_slips", n_slips, k);
      chk("off_slipcnt", slip_cnt, k);
      chk("off_gap", gap_bad, 0);
      chk("off_iserdes", iserdes_rst, 0);
    end

    // Isolated mismatches, then real loss and relock
    k = int'($urandom_range(0, 7));
    apply_reset(k);
    wait_lock(300, n);
    chk("lk_lat", n, RSTC + SETC + 2 + k * (SETC + 2));
    @(negedge clk);
    inj = 1'b1; inj_val = ~PAT;
    repeat (3) begin
      @(negedge clk);
      chk("iso_hold", locked, 1);
    end
    inj = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("iso_after", locked, 1);
    end
    force_loss();
    wait_lock(300, n);
    chk("relock_lat", n, RSTC + SETC + 1 + k * (SETC + 2));
    chk("relock_runlen", rst_bad, 0);

    // Pattern never matches: three full sweeps, then sticky fail
    apply_reset(0);
    stuck = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fail && n < 600);
    chk("fail_lat", n, 3 * SWEEP + 1);
    chk("fail_slips", n_slips, 21);
    chk("fail_runs", n_rst_runs, 3);
    chk("fail_runlen", rst_bad, 0);
    chk("fail_gap", gap_bad, 0);
    repeat (10) @(negedge clk);
    chk("fail_sticky", fail, 1);
    chk("fail_locked", locked, 0);
    chk("fail_iserdes", iserdes_rst, 0);
    pulse_start();
    chk("fstart_fail", fail, 0);
    chk("fstart_rst", iserdes_rst, 1);
    chk("fstart_slipcnt", slip_cnt, 0);

    // Reset asserted during a slip pulse
    apply_reset(3);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (bitslip) found = 1;
    end
    chk("slip_seen", found, 1);
    cpu_resetn = 1'b0;
    #1;
    chk("midslip_bitslip", bitslip, 0);
    chk("midslip_iserdes", iserdes_rst, 1);
    chk("midslip_slipcnt", slip_cnt, 0);

    // Start during the settle after the second slip
    apply_reset(3);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (bitslip && slip_cnt == 3'd2) found = 1;
    end
    chk("slip2_seen", found, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mset_rst", iserdes_rst, 1);
    chk("mset_slipcnt", slip_cnt, 0);
    chk("mset_locked", locked, 0);
    wait_lock(300, n);
    chk("mset_lat", n, RSTC + SETC + 1 + 3 * (SETC + 2));
    chk("mset_slipcnt2", slip_cnt, 3);
    chk("mset_runlen", rst_bad, 0);

`ifdef ADC_ALIGN_STATS_EN
    // Five slips then two losses with an already aligned lane
    apply_reset(5);
    wait_lock(300, n);
    offset = 0;
    force_loss();
    wait_lock(300, n);
    force_loss();
    wait_lock(300, n);
    chk("st_loss", lock_loss_cnt, 2);
    chk("st_slips", total_slips, 5);
    pulse_start();
    chk("st_loss_keep", lock_loss_cnt, 2);
    chk("st_slips_keep", total_slips, 5);
`endif

    chk("excl", excl_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
